memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_controller.sv | 104 ++++++++++
 tb/tb_memory_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// Single-outstanding request controller: bridges a valid/ready request/response
// channel to a synchronous memory whose read data arrives one cycle after the strobe.
module memory_controller #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned ADDR_SIZE  = 4096,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [DATA_SIZE-1:0]  reqWriteData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_SIZE-1:0]  memWriteData,
  output logic                  memReadEnable,
  output logic                  memWriteEnable,
  input  logic [DATA_SIZE-1:0]  memReadData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_SIZE-1:0]  rspData,
  output logic                  rspError,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
  logic [DATA_SIZE-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    addr_oor;
  logic                    accept;

  assign addr_oor = (32'(reqAddr) >= ADDR_SIZE);
  // Gated by reset so the channel reads not-ready while reset is held low.
  assign reqReady = (state_q == IDLE) && reset;
  assign accept   = reqValid && reqReady;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = reqAddr;
          wdata_d = reqWriteData;
          rdata_d = '0;
          err_d   = addr_oor;
          if (addr_oor)      state_d = RESP;
          else if (reqWrite) state_d = WRITE;
          else               state_d = READ;
        end
      end
      WRITE:   state_d = RESP;
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        rdata_d = memReadData;
        state_d = RESP;
      end
      RESP: begin
        if (rspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign memAddr        = addr_q;
  assign memWriteData   = wdata_q;
  assign memWriteEnable = (state_q == WRITE);
  assign memReadEnable  = (state_q == READ);
  assign rspValid       = (state_q == RESP);
  assign rspData        = rdata_q;
  assign rspError       = err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller with ADDR_SIZE=3000: table-driven requests checked
// through a response scoreboard, plus stall, back-to-back and mid-cycle reset sequences.
module tb_memory_controller;

  logic        clock;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [11:0] reqAddr;
  logic [7:0]  reqWriteData;
  logic [11:0] memAddr;
  logic [7:0]  memWriteData;
  logic        memReadEnable;
  logic        memWriteEnable;
  logic [7:0]  memReadData;
  logic        rspValid;
  logic        rspReady;
  logic [7:0]  rspData;
  logic        rspError;
  logic        busy;

  memory_controller #(
    .DATA_SIZE (8),
    .ADDR_SIZE (3000),
    .ADDR_WIDTH(12)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .reqWrite      (reqWrite),
    .reqAddr       (reqAddr),
    .reqWriteData  (reqWriteData),
    .memAddr       (memAddr),
    .memWriteData  (memWriteData),
    .memReadEnable (memReadEnable),
    .memWriteEnable(memWriteEnable),
    .memReadData   (memReadData),
    .rspValid      (rspValid),
    .rspReady      (rspReady),
    .rspData       (rspData),
    .rspError      (rspError),
    .busy          (busy)
  );

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  sb_t  sb[$];
  vec_t cur_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   cur_wr = 0;
  int   cur_rd = 0;
  bit   first = 0;
  logic [7:0] mem [0:4095];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural memory: read data valid the cycle after the read strobe.
  always @(posedge clock) begin
    if (memWriteEnable) mem[memAddr] <= memWriteData;
    if (memReadEnable) memReadData <= mem[memAddr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Scoreboard: push at acceptance, pop and compare at response handshake.
  always @(negedge clock) begin
    if (reset) begin
      if (memReadEnable || memWriteEnable) begin
        check("strobe_exclusive", {31'd0, memReadEnable && memWriteEnable}, 32'd0);
        if (sb.size() == 0) fail("strobe_without_request");
        else begin
          if (memWriteEnable) cur_wr++;
          if (memReadEnable) cur_rd++;
          check("mem_addr", {20'd0, memAddr}, {20'd0, sb[0].v.addr});
          if (memWriteEnable) check("mem_wdata", {24'd0, memWriteData}, {24'd0, sb[0].v.wdata});
        end
      end
      if (rspValid) begin
        if (sb.size() == 0) fail("unexpected_response");
        else begin
          if (first) begin
            first = 0;
            check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].v.exp_lat));
            check("busy_in_resp", {31'd0, busy}, 32'd1);
          end
          if (rspReady) begin
            sb_t e;
            e = sb.pop_front();
            check("rsp_data", {24'd0, rspData}, {24'd0, e.v.exp_data});
            check("rsp_error", {31'd0, rspError}, {31'd0, e.v.exp_err});
            check("write_pulses", 32'(cur_wr), (e.v.wr && !e.v.exp_err) ? 32'd1 : 32'd0);
            check("read_pulses", 32'(cur_rd), (!e.v.wr && !e.v.exp_err) ? 32'd1 : 32'd0);
            hs_cyc = cyc;
          end
        end
      end
      if (reqValid && reqReady) begin
        sb.push_back('{v: cur_exp, acc: cyc});
        cur_wr = 0;
        cur_rd = 0;
        first  = 1;
      end
    end
  end

  task automatic issue(input vec_t v, input bit hold, output int acc);
    bit got;
    got = 0;
    acc = -1;
    cur_exp      = v;
    reqWrite     = v.wr;
    reqAddr      = v.addr;
    reqWriteData = v.wdata;
    reqValid     = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clock);
      if (reqReady) begin
        got = 1;
        acc = cyc;
      end
    end
    if (!got) fail("accept_timeout");
    @(posedge clock);
    #1;
    if (!hold) reqValid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (sb.size() == 0) done = 1;
    end
    if (!done) begin
      fail("response_timeout");
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[10];
  int   acc;
  int   acc2;
  int   cnt;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    reset = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    reqWriteData = '0; rspReady = 1'b1; memReadData = '0;

    #2;
    check("rst_reqReady", {31'd0, reqReady}, 32'd0);
    check("rst_rspValid", {31'd0, rspValid}, 32'd0);
    check("rst_rspData", {24'd0, rspData}, 32'd0);
    check("rst_rspError", {31'd0, rspError}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_memRE", {31'd0, memReadEnable}, 32'd0);
    check("rst_memWE", {31'd0, memWriteEnable}, 32'd0);
    check("rst_memAddr", {20'd0, memAddr}, 32'd0);
    check("rst_memWData", {24'd0, memWriteData}, 32'd0);
    #11 reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", {31'd0, reqReady}, 32'd1);

    //        wr    addr     wdata  exp_d  err   lat
    tbl[0] = '{1'b1, 12'h010, 8'hA5, 8'h00, 1'b0, 2};
    tbl[1] = '{1'b0, 12'h010, 8'h00, 8'hA5, 1'b0, 3};
    tbl[2] = '{1'b0, 12'hBB8, 8'h00, 8'h00, 1'b1, 1};
    tbl[3] = '{1'b1, 12'hBB7, 8'h3C, 8'h00, 1'b0, 2};
    tbl[4] = '{1'b0, 12'hBB7, 8'h11, 8'h3C, 1'b0, 3};
    tbl[5] = '{1'b1, 12'hFFF, 8'h77, 8'h00, 1'b1, 1};
    tbl[6] = '{1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 3};
    tbl[7] = '{1'b1, 12'h000, 8'hFF, 8'h00, 1'b0, 2};
    tbl[8] = '{1'b0, 12'h000, 8'h00, 8'hFF, 1'b0, 3};
    tbl[9] = '{1'b0, 12'hFFF, 8'h00, 8'h00, 1'b1, 1};

    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i], 1'b0, acc);
      wait_done();
    end

    // Response stall with req* wiggling while not in IDLE.
    rspReady = 1'b0;
    issue('{1'b0, 12'h010, 8'h00, 8'hA5, 1'b0, 3}, 1'b0, acc);
    cnt = 0;
    while (!rspValid && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 12'h0FF; reqWriteData = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_rspValid", {31'd0, rspValid}, 32'd1);
      check("stall_rspData", {24'd0, rspData}, 32'h0000_00A5);
      check("stall_reqReady", {31'd0, reqReady}, 32'd0);
      check("stall_strobes", {30'd0, memReadEnable, memWriteEnable}, 32'd0);
      check("stall_memAddr", {20'd0, memAddr}, 32'h0000_0010);
    end
    @(posedge clock);
    #1;
    reqValid = 1'b0;
    rspReady = 1'b1;
    wait_done();

    // Back-to-back: reqValid held high across the first response.
    issue('{1'b1, 12'h020, 8'h5A, 8'h00, 1'b0, 2}, 1'b1, acc);
    issue('{1'b0, 12'h020, 8'h00, 8'h5A, 1'b0, 3}, 1'b0, acc2);
    check("b2b_accept_cycle", 32'(acc2), 32'(hs_cyc + 1));
    wait_done();

    // Asynchronous reset asserted mid-cycle while in READ.
    issue('{1'b0, 12'h010, 8'h00, 8'hA5, 1'b0, 3}, 1'b0, acc);
    cnt = 0;
    while (!memReadEnable && cnt < 5) begin
      @(negedge clock);
      cnt++;
    end
    check("in_read_before_reset", {31'd0, memReadEnable}, 32'd1);
    #2;
    reset = 1'b0;
    first = 0;
    sb.delete();
    #1;
    check("rst_mid_memRE", {31'd0, memReadEnable}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_reqReady", {31'd0, reqReady}, 32'd0);
    check("rst_mid_memAddr", {20'd0, memAddr}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    @(negedge clock);
    check("ready_after_mid_reset", {31'd0, reqReady}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rspValid || memReadEnable || memWriteEnable) cnt++;
    end
    check("no_rsp_after_reset", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
